// File: rtl/mux_2_1.sv
// Parameterised 2:1 word multiplexer with a registered shadow copy of the
// result and a saturating counter of select changes for pipelined consumers.
module mux_2_1 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             sel,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             sel_q,
    output logic [CNT_W-1:0] toggle_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] w_out_s;
    logic [CNT_W-1:0] w_cnt_next_s;
    logic [WIDTH-1:0] r_out_q_r;
    logic             r_sel_q_r;
    logic [CNT_W-1:0] r_cnt_r;

    // Zero-latency word select; must stay free of clock and reset.
    always_comb begin
        w_out_s = in0;
        if (sel == 1'b1) begin
            w_out_s = in1;
        end else begin
            w_out_s = in0;
        end
    end

    // Next toggle count: bump on a select change, stick at all-ones.
    always_comb begin
        w_cnt_next_s = r_cnt_r;
        if ((sel != r_sel_q_r) && (r_cnt_r != CNT_MAX)) begin
            w_cnt_next_s = r_cnt_r + CNT_ONE;
        end else begin
            w_cnt_next_s = r_cnt_r;
        end
    end

    // Shadow registers; the asynchronous clear holds for as long as rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q_r <= {WIDTH{1'b0}};
            r_sel_q_r <= 1'b0;
            r_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            r_out_q_r <= w_out_s;
            r_sel_q_r <= sel;
            r_cnt_r   <= w_cnt_next_s;
        end
    end

    assign out        = w_out_s;
    assign out_q      = r_out_q_r;
    assign sel_q      = r_sel_q_r;
    assign toggle_cnt = r_cnt_r;

endmodule

// File: tb/tb_mux_2_1.sv
// Directed self-checking bench for mux_2_1: combinational select, reset,
// register path, toggle counting and saturation (with a 4-bit counter copy).
module tb_mux_2_1;

    logic        clk;
    logic        rst_n;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        sel;
    logic        sel2;
    logic [31:0] out;
    logic [31:0] out_q;
    logic        sel_q;
    logic [15:0] toggle_cnt;
    logic [31:0] out2;
    logic [31:0] out_q2;
    logic        sel_q2;
    logic [3:0]  toggle_cnt2;

    int n_checks;
    int n_errors;

    mux_2_1 #(.WIDTH(32), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in0),
        .in1        (in1),
        .sel        (sel),
        .out        (out),
        .out_q      (out_q),
        .sel_q      (sel_q),
        .toggle_cnt (toggle_cnt)
    );

    mux_2_1 #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in0        (in0),
        .in1        (in1),
        .sel        (sel2),
        .out        (out2),
        .out_q      (out_q2),
        .sel_q      (sel_q2),
        .toggle_cnt (toggle_cnt2)
    );

    // One clock period; outputs are sampled 5 ns after the rising edge.
    task automatic tick();
        #5;
        clk = 1'b1;
        #5;
        clk = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_sel_in0();
        in0 = 32'hAAAAAAAA;
        in1 = 32'h55555555;
        sel = 1'b0;
        #10;
        n_checks++;
        if (out !== 32'hAAAAAAAA) begin
            n_errors++;
            $display("FAIL sel_in0: out=%h expected=%h", out, 32'hAAAAAAAA);
        end
    endtask

    task automatic test_sel_in1();
        sel = 1'b1;
        #10;
        n_checks++;
        if (out !== 32'h55555555) begin
            n_errors++;
            $display("FAIL sel_in1: out=%h expected=%h", out, 32'h55555555);
        end
    endtask

    task automatic test_new_data();
        in0 = 32'h12345678;
        in1 = 32'h9ABCDEF0;
        sel = 1'b0;
        #1;
        n_checks++;
        if (out !== 32'h12345678) begin
            n_errors++;
            $display("FAIL new_data_in0: out=%h expected=%h", out, 32'h12345678);
        end
        sel = 1'b1;
        #1;
        n_checks++;
        if (out !== 32'h9ABCDEF0) begin
            n_errors++;
            $display("FAIL new_data_in1: out=%h expected=%h", out, 32'h9ABCDEF0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 1'b0;
        #1;
        tick();
        n_checks++;
        if (out_q !== 32'h0 || sel_q !== 1'b0 || toggle_cnt !== 16'h0) begin
            n_errors++;
            $display("FAIL reset_hold: out_q=%h sel_q=%b cnt=%h expected=0/0/0",
                     out_q, sel_q, toggle_cnt);
        end
        n_checks++;
        if (out !== 32'h12345678) begin
            n_errors++;
            $display("FAIL reset_out_tracks: out=%h expected=%h", out, 32'h12345678);
        end
        rst_n = 1'b1;
        sel   = 1'b1;
        in1   = 32'h9ABCDEF0;
        #1;
        tick();
        n_checks++;
        if (out_q !== 32'h9ABCDEF0 || sel_q !== 1'b1 || toggle_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL first_edge: out_q=%h sel_q=%b cnt=%0d expected=9abcdef0/1/1",
                     out_q, sel_q, toggle_cnt);
        end
    endtask

    task automatic test_toggle_count();
        logic       exp_sel;
        logic [31:0] exp_q;
        pulse_reset();
        sel = 1'b0;
        in0 = 32'h0000_1111;
        in1 = 32'hFFFF_0000;
        for (int i = 0; i < 10; i++) begin
            sel = ~sel;
            exp_sel = sel;
            exp_q   = sel ? 32'hFFFF_0000 : 32'h0000_1111;
            tick();
            n_checks++;
            if (toggle_cnt !== 16'(i + 1) || sel_q !== exp_sel || out_q !== exp_q) begin
                n_errors++;
                $display("FAIL toggle_step%0d: cnt=%0d sel_q=%b out_q=%h expected=%0d/%b/%h",
                         i, toggle_cnt, sel_q, out_q, i + 1, exp_sel, exp_q);
            end
        end
        // Steady select must not count.
        tick();
        tick();
        n_checks++;
        if (toggle_cnt !== 16'd10) begin
            n_errors++;
            $display("FAIL toggle_hold: cnt=%0d expected=10", toggle_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] exp_cnt;
        pulse_reset();
        sel2 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            sel2 = ~sel2;
            tick();
            exp_cnt = (i + 1 >= 15) ? 4'hF : 4'(i + 1);
            if (i == 13 || i == 14 || i == 15 || i == 19) begin
                n_checks++;
                if (toggle_cnt2 !== exp_cnt) begin
                    n_errors++;
                    $display("FAIL saturate_edge%0d: cnt=%h expected=%h",
                             i + 1, toggle_cnt2, exp_cnt);
                end
            end
        end
        n_checks++;
        if (toggle_cnt !== 16'd0) begin
            n_errors++;
            $display("FAIL saturate_other_dut: cnt=%0d expected=0", toggle_cnt);
        end
    endtask

    task automatic test_async_reset();
        sel = 1'b1;
        in1 = 32'hCAFEF00D;
        tick();
        n_checks++;
        if (out_q !== 32'hCAFEF00D || toggle_cnt !== 16'd1) begin
            n_errors++;
            $display("FAIL pre_async: out_q=%h cnt=%0d expected=cafef00d/1", out_q, toggle_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_q !== 32'h0 || sel_q !== 1'b0 || toggle_cnt !== 16'h0 || toggle_cnt2 !== 4'h0) begin
            n_errors++;
            $display("FAIL async_clear: out_q=%h sel_q=%b cnt=%h cnt4=%h expected=0/0/0/0",
                     out_q, sel_q, toggle_cnt, toggle_cnt2);
        end
        n_checks++;
        if (out !== 32'hCAFEF00D) begin
            n_errors++;
            $display("FAIL async_out_tracks: out=%h expected=%h", out, 32'hCAFEF00D);
        end
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        sel   = 1'b0;
        sel2  = 1'b0;
        in0   = 32'h0;
        in1   = 32'h0;
        test_sel_in0();
        test_sel_in1();
        test_new_data();
        test_reset();
        test_toggle_count();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
